// File: rtl/mips_pkg.sv
// Shared definitions for the MULT/MULTU sequencer: operand width and FSM encoding.
package mips_pkg;

  localparam int MULT_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    NEG_LO = 3'd2,
    NEG_HI = 3'd3,
    DONE   = 3'd4
  } mult_state_t;

  function automatic logic state_is_busy(input mult_state_t st);
    return (st == CALC) || (st == NEG_LO) || (st == NEG_HI);
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Launch/result bundle between the control unit (master) and the multiplier (slave).
interface mult_seq_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_seq_adder.sv
// WIDTH-bit ripple-carry adder built from a chain of 1-bit full-adder cells.
module ripple_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Per-cell carry nets keep the chain free of a self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic ci;
    logic co;
    if (i == 0) begin : g_first
      assign ci = cin;
    end else begin : g_chain
      assign ci = g_bit[i-1].co;
    end
    assign sum[i] = x[i] ^ y[i] ^ ci;
    assign co     = (x[i] & y[i]) | (ci & (x[i] ^ y[i]));
  end

  assign cout = g_bit[WIDTH-1].co;

endmodule

// File: rtl/mult_seq.sv
// Shift-add multiplier for MULT/MULTU: one shared adder, fixed WIDTH+2 cycle latency.
//
// state  | meaning
// IDLE   | waiting for start; hi/lo hold the last product
// CALC   | WIDTH shift-add steps on magnitudes
// NEG_LO | lo <= acc_lo, negated when the product sign is negative
// NEG_HI | hi <= acc_hi, negated with the borrow from NEG_LO
// DONE   | one-cycle done pulse; start here relaunches directly
module mult_seq
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic      clk,
  input  logic      rst_n,
  mult_seq_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  mult_state_t      state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             neg;
  logic             borrow;

  logic [WIDTH-1:0] add_x;
  logic [WIDTH-1:0] add_y;
  logic             add_cin;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;

  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             launch_neg;

  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
  always_comb begin
    mag_a      = (bus.is_signed && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    mag_b      = (bus.is_signed && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
    launch_neg = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
  end

  always_comb begin
    add_x   = acc_hi;
    add_y   = acc_lo[0] ? mcand : '0;
    add_cin = 1'b0;
    case (state)
      NEG_LO: begin
        add_x   = ~acc_lo;
        add_y   = '0;
        add_cin = 1'b1;
      end
      NEG_HI: begin
        add_x   = ~acc_hi;
        add_y   = '0;
        add_cin = borrow;
      end
      default: ;
    endcase
  end

  ripple_adder #(
    .WIDTH(WIDTH)
  ) u_adder (
    .x   (add_x),
    .y   (add_y),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      neg    <= 1'b0;
      borrow <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            mcand    <= mag_a;
            acc_hi   <= '0;
            acc_lo   <= mag_b;
            neg      <= launch_neg;
            cnt      <= '0;
            state    <= CALC;
            bus.busy <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end
        CALC: begin
          {acc_hi, acc_lo} <= {add_cout, add_sum, acc_lo[WIDTH-1:1]};
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            state <= NEG_LO;
          end
        end
        NEG_LO: begin
          if (neg) begin
            bus.lo <= add_sum;
            borrow <= add_cout;
          end else begin
            bus.lo <= acc_lo;
            borrow <= 1'b0;
          end
          state <= NEG_HI;
        end
        NEG_HI: begin
          bus.hi   <= neg ? add_sum : acc_hi;
          state    <= DONE;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          bus.busy <= state_is_busy(IDLE);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
// Directed-vector bench for mult_seq: latency, signed/unsigned products, back-to-back, async reset.
module tb_mult_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mult_seq_if #(.WIDTH(32)) dif ();

  mult_seq #(
    .WIDTH(32)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Presents one launch at the next edge, then scrambles the operands.
  task automatic launch(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dif.start     = 1'b1;
    dif.is_signed = s;
    dif.a         = a;
    dif.b         = b;
    @(posedge clk);
    #1;
    dif.start     = 1'b0;
    dif.is_signed = ~s;
    dif.a         = 32'hDEAD_BEEF;
    dif.b         = 32'h1234_5678;
  endtask

  // lat = negedge index (index first_j = first negedge after the launch edge) where done is seen.
  task automatic wait_done(input int first_j, output int lat, output int busy_low);
    lat      = -1;
    busy_low = 0;
    for (int j = first_j; j < first_j + 200; j++) begin
      @(negedge clk);
      if (dif.done) begin
        lat = j;
        break;
      end
      if (!dif.busy) busy_low++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (dif.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_busy: got %b want 0", dif.busy);
    end
    checks++;
    if (dif.done !== 1'b0) begin
      failures++;
      $display("FAIL reset_done: got %b want 0", dif.done);
    end
    checks++;
    if ({dif.hi, dif.lo} !== 64'h0) begin
      failures++;
      $display("FAIL reset_hilo: got %h_%h want 0", dif.hi, dif.lo);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu_small();
    int lat, busy_low;
    launch(1'b0, 32'd3, 32'd5);
    wait_done(0, lat, busy_low);
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL small_latency: got %0d want 34", lat);
    end
    checks++;
    if (busy_low !== 0) begin
      failures++;
      $display("FAIL small_busy: busy low in %0d cycles want 0", busy_low);
    end
    checks++;
    if (dif.busy !== 1'b0) begin
      failures++;
      $display("FAIL small_busy_at_done: got %b want 0", dif.busy);
    end
    checks++;
    if ({dif.hi, dif.lo} !== 64'h0000_0000_0000_000F) begin
      failures++;
      $display("FAIL small_product: got %h_%h want 00000000_0000000f", dif.hi, dif.lo);
    end
    @(negedge clk);
    checks++;
    if (dif.done !== 1'b0) begin
      failures++;
      $display("FAIL small_done_pulse: got %b want 0", dif.done);
    end
    checks++;
    if (dif.lo !== 32'h0000_000F) begin
      failures++;
      $display("FAIL small_hold: got %h want 0000000f", dif.lo);
    end
  endtask

  task automatic test_multu_max();
    int lat, busy_low;
    launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (6) @(negedge clk);
    checks++;
    if ({dif.hi, dif.lo} !== 64'h0000_0000_0000_000F) begin
      failures++;
      $display("FAIL max_hold_in_calc: got %h_%h want 00000000_0000000f", dif.hi, dif.lo);
    end
    wait_done(6, lat, busy_low);
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL max_latency: got %0d want 34", lat);
    end
    checks++;
    if ({dif.hi, dif.lo} !== 64'hFFFF_FFFE_0000_0001) begin
      failures++;
      $display("FAIL max_product: got %h_%h want fffffffe_00000001", dif.hi, dif.lo);
    end
  endtask

  task automatic test_mult_signed();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [63:0] vp [4];
    int lat, busy_low;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001; vp[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    va[1] = 32'h8000_0000; vb[1] = 32'h8000_0000; vp[1] = 64'h4000_0000_0000_0000;
    va[2] = 32'hFFFF_FFF9; vb[2] = 32'h0000_0006; vp[2] = 64'hFFFF_FFFF_FFFF_FFD6;
    va[3] = 32'hFFFF_FFFD; vb[3] = 32'hFFFF_FFFB; vp[3] = 64'h0000_0000_0000_000F;
    for (int i = 0; i < 4; i++) begin
      launch(1'b1, va[i], vb[i]);
      wait_done(0, lat, busy_low);
      checks++;
      if (lat !== 34) begin
        failures++;
        $display("FAIL signed_latency[%0d]: got %0d want 34", i, lat);
      end
      checks++;
      if ({dif.hi, dif.lo} !== vp[i]) begin
        failures++;
        $display("FAIL signed_product[%0d]: got %h_%h want %h", i, dif.hi, dif.lo, vp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic        ps [3];
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    logic [63:0] pp [3];
    int idx, last, n_done;
    ps[0] = 1'b1; pa[0] = 32'hFFFF_FFF9; pb[0] = 32'h0000_0006; pp[0] = 64'hFFFF_FFFF_FFFF_FFD6;
    ps[1] = 1'b0; pa[1] = 32'h0001_0000; pb[1] = 32'h0001_0000; pp[1] = 64'h0000_0001_0000_0000;
    ps[2] = 1'b1; pa[2] = 32'h7FFF_FFFF; pb[2] = 32'h0000_0002; pp[2] = 64'h0000_0000_FFFF_FFFE;
    @(negedge clk);
    dif.start     = 1'b1;
    dif.is_signed = ps[0];
    dif.a         = pa[0];
    dif.b         = pb[0];
    idx    = 1;
    last   = -1;
    n_done = 0;
    for (int j = 0; j < 300 && n_done < 3; j++) begin
      @(negedge clk);
      if (dif.done) begin
        checks++;
        if ({dif.hi, dif.lo} !== pp[n_done]) begin
          failures++;
          $display("FAIL b2b_product[%0d]: got %h_%h want %h", n_done, dif.hi, dif.lo, pp[n_done]);
        end
        checks++;
        if ((j - last) !== ((n_done == 0) ? 35 : 35)) begin
          if (!(n_done == 0 && j == 34)) begin
            failures++;
            $display("FAIL b2b_spacing[%0d]: got %0d want %0d", n_done, (n_done == 0) ? j : j - last,
                     (n_done == 0) ? 34 : 35);
          end
        end
        last = j;
        n_done++;
        if (idx < 3) begin
          dif.is_signed = ps[idx];
          dif.a         = pa[idx];
          dif.b         = pb[idx];
          idx++;
        end else begin
          dif.start = 1'b0;
        end
      end else begin
        dif.is_signed = j[0];
        dif.a         = 32'(j) * 32'h0101_0101;
        dif.b         = ~(32'(j) * 32'h0011_0011);
      end
    end
    dif.start = 1'b0;
    checks++;
    if (n_done !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d done pulses want 3", n_done);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, busy_low, stray;
    launch(1'b0, 32'h0000_1234, 32'h0000_0100);
    repeat (11) @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dif.busy, dif.done} !== 2'b00) begin
      failures++;
      $display("FAIL midreset_ctrl: got busy=%b done=%b want 0 0", dif.busy, dif.done);
    end
    checks++;
    if ({dif.hi, dif.lo} !== 64'h0) begin
      failures++;
      $display("FAIL midreset_hilo: got %h_%h want 0", dif.hi, dif.lo);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (dif.done || dif.busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL midreset_no_done: got %0d active cycles want 0", stray);
    end
    launch(1'b1, 32'd100, 32'hFFFF_FFFD);
    wait_done(0, lat, busy_low);
    checks++;
    if (lat !== 34) begin
      failures++;
      $display("FAIL midreset_latency: got %0d want 34", lat);
    end
    checks++;
    if ({dif.hi, dif.lo} !== 64'hFFFF_FFFF_FFFF_FED4) begin
      failures++;
      $display("FAIL midreset_product: got %h_%h want ffffffff_fffffed4", dif.hi, dif.lo);
    end
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    dif.start     = 1'b0;
    dif.is_signed = 1'b0;
    dif.a         = '0;
    dif.b         = '0;
    test_reset();
    test_multu_small();
    test_multu_max();
    test_mult_signed();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
